// File: rtl/rtc_bus_pkg.sv
// Shared types and timing defaults for the RTC parallel-bus sequencer.
// The counter-width helper sizes the shared down-counter for the longest phase.
package rtc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        TURN   = 2'd3
    } state_e;

    localparam int DEF_DRIVE_CYC  = 4;
    localparam int DEF_SAMPLE_CYC = 3;
    localparam int DEF_TURN_CYC   = 1;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer.sv
// Runs one bus transaction per request: a write drives latched data, a read
// releases the bus and captures it, each followed by an optional turnaround.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DRIVE_CYC  = DEF_DRIVE_CYC,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
    parameter int TURN_CYC   = DEF_TURN_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              w_r,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);

    localparam int CW = cnt_width(DRIVE_CYC, SAMPLE_CYC, TURN_CYC);
    localparam logic [CW-1:0] DRIVE_LD  = CW'(DRIVE_CYC - 1);
    localparam logic [CW-1:0] SAMPLE_LD = CW'(SAMPLE_CYC - 1);
    localparam logic [CW-1:0] TURN_LD   = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic              bus_oe_q, bus_oe_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        bus_out_d  = bus_out_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d = w_r;
                    if (w_r) begin
                        state_d   = DRIVE;
                        cnt_d     = DRIVE_LD;
                        bus_out_d = wr_data;
                    end else begin
                        state_d = SAMPLE;
                        cnt_d   = SAMPLE_LD;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    if (TURN_CYC == 0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = TURN;
                        cnt_d   = TURN_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt_q == '0) begin
                    // Capture only on the edge closing the final sample cycle.
                    rd_data_d = bus_in;
                    if (TURN_CYC == 0) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        done_d     = 1'b1;
                        rd_valid_d = 1'b1;
                    end else begin
                        state_d = TURN;
                        cnt_d   = TURN_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TURN: begin
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    done_d     = 1'b1;
                    rd_valid_d = ~wr_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        bus_oe_d = (state_d == DRIVE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            bus_out_q  <= '0;
            bus_oe_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            bus_out_q  <= bus_out_d;
            bus_oe_q   <= bus_oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
